// File: rtl/keccak_perm_arbiter.sv
// Shares one KECCAK_p permutation core among NUM_REQ hash front-ends: arbitrate, load, run, return.
// Define KECCAK_ARB_FIXED_PRIO_EN for fixed lowest-index priority; default is round-robin.
module keccak_perm_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int PERM_CYCLES = 26,
  parameter int NR          = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*1600-1:0] state_in,
  output logic [NUM_REQ-1:0]      gnt,
  output logic [NUM_REQ-1:0]      done,
  output logic [1599:0]           state_out,
  output logic                    busy,
  output logic [1599:0]           kp_S,
  output logic [4:0]              kp_nr,
  output logic                    kp_string_val,
  input  logic [1599:0]           kp_S_out
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (PERM_CYCLES > 1) ? $clog2(PERM_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               state_reg, state_next;
  logic [NUM_REQ-1:0]   gnt_reg;
  logic [IDX_W-1:0]     owner_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic [1599:0]        kp_S_reg;
  logic [1599:0]        state_out_reg;

  logic [NUM_REQ-1:0]   arb_req;
  logic [IDX_W-1:0]     arb_start;
  logic [IDX_W-1:0]     arb_idx;
  logic [IDX_W-1:0]     pos_idx;
  logic                 arb_found;
  logic                 last_cycle;
  logic                 load;
  int                   arb_pos;

  logic [1599:0] lane [NUM_REQ];
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
    assign lane[gi] = state_in[gi*1600 +: 1600];
  end

`ifdef KECCAK_ARB_FIXED_PRIO_EN
  assign arb_start = '0;
`else
  logic [IDX_W-1:0] ptr_reg;
  logic [IDX_W-1:0] owner_inc;

  assign owner_inc = (int'(owner_reg) == NUM_REQ - 1) ? '0 : owner_reg + IDX_W'(1);
  // During DONE the search starts just past the finishing owner, matching the pointer update.
  assign arb_start = (state_reg == S_DONE) ? owner_inc : ptr_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg <= '0;
    end else if (state_reg == S_DONE) begin
      ptr_reg <= owner_inc;
    end
  end
`endif

  // The finishing owner is excluded so it cannot win its own DONE slot.
  assign arb_req    = (state_reg == S_DONE) ? (req & ~gnt_reg) : req;
  assign last_cycle = (cnt_reg == CNT_W'(PERM_CYCLES - 1));
  assign load       = arb_found && (state_reg != S_RUN);

  // Scan from the highest offset down so the nearest set request overwrites the rest.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_pos   = 0;
    pos_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      arb_pos = int'(arb_start) + k;
      if (arb_pos >= NUM_REQ) begin
        arb_pos = arb_pos - NUM_REQ;
      end
      pos_idx = IDX_W'(arb_pos);
      if (arb_req[pos_idx]) begin
        arb_found = 1'b1;
        arb_idx   = pos_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (arb_found) state_next = S_RUN;
      S_RUN:   if (last_cycle) state_next = S_DONE;
      S_DONE:  state_next = arb_found ? S_RUN : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    kp_string_val = 1'b0;
    busy          = 1'b0;
    done          = '0;
    case (state_reg)
      S_RUN: begin
        kp_string_val = 1'b1;
        busy          = 1'b1;
      end
      S_DONE: begin
        busy = 1'b1;
        done = gnt_reg;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_reg       <= '0;
      owner_reg     <= '0;
      cnt_reg       <= '0;
      kp_S_reg      <= '0;
      state_out_reg <= '0;
    end else begin
      if (load) begin
        gnt_reg   <= NUM_REQ'(1) << arb_idx;
        owner_reg <= arb_idx;
        kp_S_reg  <= lane[arb_idx];
        cnt_reg   <= '0;
      end else if (state_reg == S_DONE) begin
        gnt_reg <= '0;
      end
      if (state_reg == S_RUN) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
        if (last_cycle) begin
          state_out_reg <= kp_S_out;
        end
      end
    end
  end

  assign gnt       = gnt_reg;
  assign kp_S      = kp_S_reg;
  assign state_out = state_out_reg;
  assign kp_nr     = 5'(NR);

endmodule
